// File: rtl/uart_core.sv
// UART transceiver: CLK_DIV-cycle bit timer, LSB-first frames, show-ahead RX FIFO with sticky flags.
// Define UART_PARITY_EN to add an even-parity bit after the data bits on both TX and RX.
module uart_core #(
    parameter int CLK_DIV    = 10416,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_BITS-1:0]             tx_data,
    input  logic                             tx_valid,
    output logic                             tx_ready,
    output logic                             tx_out,
    input  logic                             rx_in,
    output logic [DATA_BITS-1:0]             rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_count,
    output logic                             rx_ore,
    output logic                             rx_ferr,
    output logic                             rx_perr,
    input  logic                             err_clr
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               tx_state, tx_state_nxt;
    logic [DW-1:0]        tx_cnt;
    logic [BW-1:0]        tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_tick, tx_go;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_tick = (tx_cnt == DIV_LAST);
    assign tx_go   = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= S_IDLE;
        else     tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            S_IDLE:   if (tx_go) tx_state_nxt = S_START;
            S_START:  if (tx_tick) tx_state_nxt = S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_state_nxt = S_PARITY;
            S_PARITY: if (tx_tick) tx_state_nxt = S_STOP;
`else
            S_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_state_nxt = S_STOP;
`endif
            S_STOP:   if (tx_tick) tx_state_nxt = S_IDLE;
            default:  tx_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tx_out   = 1'b1;
        tx_ready = (tx_state == S_IDLE);
        case (tx_state)
            S_START:  tx_out = 1'b0;
            S_DATA:   tx_out = tx_shift[0];
`ifdef UART_PARITY_EN
            S_PARITY: tx_out = tx_par;
`endif
            default:  tx_out = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || tx_state == S_IDLE) begin
            tx_cnt <= '0;
            tx_bit <= '0;
        end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            if (tx_state == S_DATA && tx_tick) tx_bit <= tx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_go) begin
            tx_shift <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= ^tx_data;
`endif
        end else if (tx_state == S_DATA && tx_tick) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // Receive path: synchroniser stages, then mid-bit sampling timed from the start edge
    logic                 rx_sync_p0, rx_sync_p1, rx_sync_p2;
    state_t               rx_state, rx_state_nxt;
    logic [DW-1:0]        rx_cnt;
    logic [BW-1:0]        rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_tick, rx_fall, rx_bad_par;
    logic                 push_req, ferr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_sync_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_sync_p1 <= rx_sync_p0;
            rx_sync_p2 <= rx_sync_p1;
        end
    end

    assign rx_fall = rx_sync_p2 && !rx_sync_p1;
    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= S_IDLE;
        else     rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            S_IDLE:   if (rx_fall) rx_state_nxt = S_START;
            S_START:  if (rx_tick) rx_state_nxt = rx_sync_p1 ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
            S_DATA:   if (rx_tick && rx_bit == BIT_LAST) rx_state_nxt = S_PARITY;
            S_PARITY: if (rx_tick) rx_state_nxt = S_STOP;
`else
            S_DATA:   if (rx_tick && rx_bit == BIT_LAST) rx_state_nxt = S_STOP;
`endif
            S_STOP:   if (rx_tick) rx_state_nxt = S_IDLE;
            default:  rx_state_nxt = S_IDLE;
        endcase
    end

`ifdef UART_PARITY_EN
    logic perr_set;

    always_comb begin
        push_req = 1'b0;
        ferr_set = 1'b0;
        perr_set = 1'b0;
        if (rx_tick && rx_state == S_PARITY) perr_set = rx_sync_p1 ^ (^rx_shift);
        if (rx_tick && rx_state == S_STOP) begin
            push_req = rx_sync_p1 && !rx_bad_par;
            ferr_set = !rx_sync_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_state == S_IDLE) rx_bad_par <= 1'b0;
        else if (perr_set)             rx_bad_par <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) rx_perr <= 1'b0;
        else     rx_perr <= perr_set || (rx_perr && !err_clr);
    end
`else
    assign rx_bad_par = 1'b0;
    assign rx_perr    = 1'b0;

    always_comb begin
        push_req = 1'b0;
        ferr_set = 1'b0;
        if (rx_tick && rx_state == S_STOP) begin
            push_req = rx_sync_p1 && !rx_bad_par;
            ferr_set = !rx_sync_p1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || rx_state == S_IDLE) begin
            rx_cnt <= DIV_HALF;
            rx_bit <= '0;
        end else begin
            rx_cnt <= rx_tick ? DIV_LAST : rx_cnt - 1'b1;
            if (rx_state == S_DATA && rx_tick) rx_bit <= rx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_tick) rx_shift <= {rx_sync_p1, rx_shift[DATA_BITS-1:1]};
    end

    // Show-ahead FIFO: a push into a full FIFO only lands when a pop frees a slot that cycle
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 full, pop, push, ore_set;

    assign full     = (rx_count == CW'(FIFO_DEPTH));
    assign rx_valid = (rx_count != '0);
    assign pop      = rx_valid && rx_ready;
    assign push     = push_req && (!full || pop);
    assign ore_set  = push_req && full && !pop;
    assign rx_data  = rx_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      rx_count <= rx_count + 1'b1;
            else if (pop && !push) rx_count <= rx_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ore  <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_ore  <= ore_set  || (rx_ore  && !err_clr);
            rx_ferr <= ferr_set || (rx_ferr && !err_clr);
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: vector tables for TX framing and RX injection, hand sequences, and
// randomized rounds checked against a queue-based reference of the FIFO.
module tb_uart_core;
    localparam int CLK_DIV    = 16;
    localparam int DATA_BITS  = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NB = DATA_BITS + 2 + (PAR_EN ? 1 : 0);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DATA_BITS-1:0] tx_data = '0;
    logic                 tx_valid = 1'b0;
    logic                 tx_ready, tx_out;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready = 1'b0;
    logic [2:0]           rx_count;
    logic                 rx_ore, rx_ferr, rx_perr;
    logic                 err_clr = 1'b0;
    logic                 loop = 1'b0;
    logic                 rx_drv = 1'b1;

    int total = 0;
    int bad   = 0;

    assign rx_in = loop ? tx_out : rx_drv;

    uart_core #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_out(tx_out), .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_count(rx_count), .rx_ore(rx_ore), .rx_ferr(rx_ferr),
        .rx_perr(rx_perr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
    } tx_vec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic [2:0] exp_count;
        logic       exp_ferr;
    } rx_vec_t;

    tx_vec_t tx_tab[5];
    rx_vec_t rx_tab[4];
    logic [7:0] model_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        int n;
        n = 0;
        while (!tx_ready && n < 2000) begin
            cyc(1);
            n++;
        end
        if (n >= 2000) check("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        cyc(CLK_DIV);
    endtask

    task automatic drive_frame_p(input logic [7:0] d, input logic p, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(p);
        drive_bit(stop_b);
        rx_drv = 1'b1;
        cyc(4);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_b);
        drive_frame_p(d, ^d, stop_b);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check(name, {24'b0, rx_data}, {24'b0, exp});
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic p, input int j);
        if (j == 0) return 1'b0;
        if (j <= DATA_BITS) return d[j-1];
        if (PAR_EN && j == DATA_BITS + 1) return p;
        return 1'b1;
    endfunction

    initial begin
        tx_tab[0] = '{8'hA5, 1'b0};
        tx_tab[1] = '{8'h01, 1'b1};
        tx_tab[2] = '{8'hFF, 1'b0};
        tx_tab[3] = '{8'h00, 1'b0};
        tx_tab[4] = '{8'h80, 1'b1};
        rx_tab[0] = '{8'h3C, 1'b1, 1'b0, 3'd1, 1'b0};
        rx_tab[1] = '{8'h81, 1'b0, 1'b0, 3'd0, 1'b1};
        rx_tab[2] = '{8'h00, 1'b1, 1'b1, 3'd0, 1'b0};
        rx_tab[3] = '{8'hC7, 1'b1, 1'b0, 3'd1, 1'b0};

        cyc(3);
        rst = 1'b0;
        check("rst_tx_out", {31'b0, tx_out}, 32'd1);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_rx_count", {29'b0, rx_count}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data}, 32'd0);
        check("rst_flags", {29'b0, rx_ore, rx_ferr, rx_perr}, 32'd0);
        rx_ready = 1'b1;
        cyc(2);
        rx_ready = 1'b0;
        check("pop_empty_count", {29'b0, rx_count}, 32'd0);

        // TX framing: every bit slot must hold its level for exactly CLK_DIV cycles
        for (int v = 0; v < 5; v++) begin
            send_tx(tx_tab[v].data);
            for (int j = 0; j < NB; j++) begin
                logic ok;
                ok = 1'b1;
                for (int c = 0; c < CLK_DIV; c++) begin
                    if (tx_out !== frame_bit(tx_tab[v].data, tx_tab[v].par, j)) ok = 1'b0;
                    if (j == NB - 1 && c == CLK_DIV - 1 && tx_ready !== 1'b0) ok = 1'b0;
                    cyc(1);
                end
                check($sformatf("tx%0d_slot%0d", v, j), {31'b0, ok}, 32'd1);
            end
            check($sformatf("tx%0d_ready_back", v), {31'b0, tx_ready}, 32'd1);
        end

        // RX injection table: one frame each from an empty FIFO with clear flags
        for (int v = 0; v < 4; v++) begin
            if (rx_tab[v].glitch) begin
                rx_drv = 1'b0;
                cyc(4);
                rx_drv = 1'b1;
                cyc(3 * CLK_DIV);
            end else begin
                drive_frame(rx_tab[v].data, rx_tab[v].stop);
            end
            check($sformatf("rxv%0d_count", v), {29'b0, rx_count}, {29'b0, rx_tab[v].exp_count});
            check($sformatf("rxv%0d_ferr", v), {31'b0, rx_ferr}, {31'b0, rx_tab[v].exp_ferr});
            check($sformatf("rxv%0d_ore", v), {31'b0, rx_ore}, 32'd0);
            if (rx_tab[v].exp_count != 0) pop_check($sformatf("rxv%0d_data", v), rx_tab[v].data);
            clear_flags();
        end

        // Loopback of three bytes
        loop = 1'b1;
        send_tx(8'h3C);
        send_tx(8'hFF);
        send_tx(8'h00);
        cyc(NB * CLK_DIV + 20);
        check("lb_count", {29'b0, rx_count}, 32'd3);
        check("lb_valid", {31'b0, rx_valid}, 32'd1);
        pop_check("lb_0", 8'h3C);
        pop_check("lb_1", 8'hFF);
        pop_check("lb_2", 8'h00);
        check("lb_flags", {29'b0, rx_ore, rx_ferr, rx_perr}, 32'd0);
        check("lb_empty", {29'b0, rx_count}, 32'd0);
        loop = 1'b0;

        // Overrun: five frames into a four-entry FIFO
        for (int i = 1; i <= 5; i++) drive_frame(8'(i * 8'h11), 1'b1);
        check("ovr_count", {29'b0, rx_count}, 32'd4);
        check("ovr_ore", {31'b0, rx_ore}, 32'd1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr_head%0d", i), 8'(i * 8'h11));
        check("ovr_ore_sticky", {31'b0, rx_ore}, 32'd1);
        clear_flags();
        check("ovr_ore_clr", {31'b0, rx_ore}, 32'd0);

`ifdef UART_PARITY_EN
        drive_frame_p(8'h01, 1'b0, 1'b1);
        check("par_bad_perr", {31'b0, rx_perr}, 32'd1);
        check("par_bad_count", {29'b0, rx_count}, 32'd0);
        clear_flags();
        drive_frame_p(8'h01, 1'b1, 1'b1);
        check("par_ok_perr", {31'b0, rx_perr}, 32'd0);
        check("par_ok_count", {29'b0, rx_count}, 32'd1);
        pop_check("par_ok_data", 8'h01);
`endif

        // Reset in the middle of data bit 3 on both directions
        drive_frame(8'h77, 1'b1);
        check("mid_pre_count", {29'b0, rx_count}, 32'd1);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        rx_drv   = 1'b0;
        cyc(1);
        tx_valid = 1'b0;
        cyc(CLK_DIV - 1);
        for (int i = 0; i < 3; i++) drive_bit(tx_data[i]);
        rx_drv = tx_data[3];
        cyc(CLK_DIV / 2);
        check("mid_busy", {31'b0, tx_ready}, 32'd0);
        rst    = 1'b1;
        rx_drv = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("mid_tx_out", {31'b0, tx_out}, 32'd1);
        check("mid_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("mid_rx_count", {29'b0, rx_count}, 32'd0);
        cyc(2 * CLK_DIV);
        loop = 1'b1;
        send_tx(8'h5A);
        cyc(NB * CLK_DIV + 20);
        check("mid_after_count", {29'b0, rx_count}, 32'd1);
        pop_check("mid_after_data", 8'h5A);
        check("mid_after_flags", {29'b0, rx_ore, rx_ferr, rx_perr}, 32'd0);
        loop = 1'b0;

        // Randomized rounds against a queue model of the FIFO
        for (int r = 0; r < 8; r++) begin
            logic exp_ore, exp_ferr;
            int n;
            exp_ore  = 1'b0;
            exp_ferr = 1'b0;
            model_q.delete();
            if (r % 2 == 0) begin
                n = $urandom_range(1, 3);
                loop = 1'b1;
                for (int i = 0; i < n; i++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    send_tx(d);
                    model_q.push_back(d);
                end
                cyc(NB * CLK_DIV + 20);
                loop = 1'b0;
            end else begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) begin
                    logic [7:0] d;
                    logic s;
                    d = 8'($urandom);
                    s = ($urandom_range(0, 4) != 0);
                    drive_frame(d, s);
                    if (!s) exp_ferr = 1'b1;
                    else if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
                    else exp_ore = 1'b1;
                end
            end
            check($sformatf("rnd%0d_count", r), {29'b0, rx_count}, 32'(model_q.size()));
            check($sformatf("rnd%0d_ore", r), {31'b0, rx_ore}, {31'b0, exp_ore});
            check($sformatf("rnd%0d_ferr", r), {31'b0, rx_ferr}, {31'b0, exp_ferr});
            while (model_q.size() > 0) pop_check($sformatf("rnd%0d_data", r), model_q.pop_front());
            check($sformatf("rnd%0d_drained", r), {31'b0, rx_valid}, 32'd0);
            clear_flags();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_core.md
# uart_core

Parametrised UART transceiver with a runtime-independent baud divider, configurable data width, a show-ahead RX FIFO with overrun/framing flags and a ready/valid TX interface. It replaces the fixed 8-bit single-register UART wrapper as the serial endpoint between board I/O pins and the on-chip command/data logic.

## Interface
- CLK_DIV, 10416, clock cycles per bit period (≥ 4)
- DATA_BITS, 8, data bits per frame (5..8)
- FIFO_DEPTH, 16, RX FIFO entries (power of 2, ≥ 2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tx_data  in  DATA_BITS  byte to transmit
- tx_valid  in  1  transmit request
- tx_ready  out  1  transmitter idle, accepts tx_data this cycle
- tx_out  out  1  serial TX pin, idle high
- rx_in  in  1  serial RX pin (asynchronous)
- rx_data  out  DATA_BITS  FIFO head (valid when rx_valid)
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  pop FIFO head
- rx_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- rx_ore  out  1  sticky overrun flag
- rx_ferr  out  1  sticky framing-error flag
- rx_perr  out  1  sticky parity-error flag (0 when parity compiled out)
- err_clr  in  1  clears all sticky flags

## Operation
- Reset: tx_out=1, tx_ready=1, rx_valid=0, rx_count=0, rx_data=0, all flags=0, both FSMs IDLE, synchroniser flops=1.
- TX FSM IDLE→START→DATA→[PARITY]→STOP→IDLE. Transfer on tx_valid&&tx_ready: data latched, tx_ready drops next cycle. Each state holds tx_out for exactly CLK_DIV cycles; data LSB first.
- RX: rx_in through 2-flop synchroniser. FSM IDLE→START→DATA→[PARITY]→STOP→IDLE.
  - IDLE: synchronised falling edge → START, counter loads CLK_DIV/2.
  - START: sample at mid-bit; 0 → DATA, 1 → IDLE (glitch, no flag).
  - DATA: DATA_BITS samples, one per CLK_DIV, LSB first.
  - STOP: sample 1 → push byte; sample 0 → byte dropped, rx_ferr set; FSM returns to IDLE either way and waits for next falling edge.
- FIFO: push on good stop bit; pop on rx_valid&&rx_ready. Full and no pop: byte dropped, rx_ore set, FIFO contents unchanged. Full with pop same cycle: push accepted, count unchanged. Pop on empty ignored. Pointers wrap mod FIFO_DEPTH.
- err_clr clears flags; a flag-setting event in the same cycle wins (flag stays 1).
- tx_valid held while busy is ignored until tx_ready returns; no queuing.

## Timing
- TX: first start-bit cycle on tx_out is the cycle after handshake; frame length (DATA_BITS+2[+1])·CLK_DIV cycles; tx_ready=1 the cycle after the last stop-bit cycle (back-to-back handshake allowed there).
- RX: byte visible on rx_data/rx_valid one cycle after the stop-bit mid-sample; latency from rx_in falling edge ≈ 2 (sync) + (DATA_BITS+1.5)·CLK_DIV [+CLK_DIV] + 1 cycles.
- rx_count, rx_valid update the cycle after push/pop.
- rst mid-frame: both FSMs abort, tx_out=1 next cycle, FIFO emptied, partial RX byte discarded.

## Configuration
- UART_PARITY_EN defined: one even-parity bit after data on TX; RX checks it, mismatch sets rx_perr and drops the byte (not pushed). Frame is DATA_BITS+3 bits.
- Undefined: no parity state, frame DATA_BITS+2 bits, rx_perr tied 0.

## Test plan (CLK_DIV=16, DATA_BITS=8, FIFO_DEPTH=4)
- Send 0xA5 via tx_valid → tx_out low 16 cycles, bits 1,0,1,0,0,1,0,1 each 16 cycles, high 16 cycles; tx_ready back after 160 cycles (176 with parity).
- Loop tx_out→rx_in, send 0x3C, 0xFF, 0x00 → rx_count reaches 3, pops yield 0x3C, 0xFF, 0x00, no flags.
- Receive 5 frames with rx_ready=0 → rx_count=4, rx_ore=1, heads 1..4 intact; err_clr → rx_ore=0.
- Frame with stop bit 0 → no push, rx_ferr=1; 4-cycle low glitch on idle line → no push, no flags.
- With UART_PARITY_EN, inject 0x01 with parity bit 0 → rx_perr=1, rx_count unchanged; correct parity → pushed.
- Assert rst at data bit 3 of both TX and RX → tx_out=1, tx_ready=1, rx_count=0 next cycle; following frame 0x5A received correctly.
